// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Purpose : Shared timing constants for the 640x480@60 VGA controller.
//           The horizontal and vertical segment lengths appear in scan order
//           (sync, back porch, visible, front porch). The package also holds
//           the derived totals, the visible-region boundaries, the maximum
//           renderer latency, the packed type carried through the sync delay
//           line, and a helper that expands one colour bit to a full channel.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_BACK      = 48;
    localparam int unsigned H_VISIBLE   = 640;
    localparam int unsigned H_FRONT     = 16;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_BACK      = 33;
    localparam int unsigned V_VISIBLE   = 480;
    localparam int unsigned V_FRONT     = 10;

    localparam int unsigned H_TOTAL     = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;  // 800
    localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;  // 525

    localparam int unsigned H_VIS_START = H_SYNC + H_BACK;                        // 144
    localparam int unsigned H_VIS_END   = H_VIS_START + H_VISIBLE;                // 784
    localparam int unsigned V_VIS_START = V_SYNC + V_BACK;                        // 35
    localparam int unsigned V_VIS_END   = V_VIS_START + V_VISIBLE;                // 515

    localparam int unsigned DEPTH_MAX   = 4;
    localparam int unsigned CNT_W       = 10;

    // Timing bits carried through the delay line (hs/vs are active low)
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } vga_tim_t;

    localparam vga_tim_t TIM_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

    // Expand a single colour bit to a full-scale 8-bit channel
    function automatic logic [7:0] bar_level(input logic bit_v);
        if (bit_v) begin
            return 8'hFF;
        end else begin
            return 8'h00;
        end
    endfunction

endpackage

// File: rtl/vga_controlador_if.sv
// -----------------------------------------------------------------------------
// vga_controlador_if
// Purpose : Bundles the renderer/DAC side of the VGA controller.
//   VGA_X, VGA_Y               scan coordinates published to the renderer
//   pix_r, pix_g, pix_b        renderer colour returned PIPE_DELAY cycles later
//   VGA_HS, VGA_VS             active-low syncs aligned to the colour
//   VGA_BLANK_N, VGA_SYNC_N    DAC blanking (high when visible) and sync-on-green (0)
//   VGA_R, VGA_G, VGA_B        registered DAC colour
// Modports: master = controller, slave = renderer / DAC consumer.
// -----------------------------------------------------------------------------
interface vga_controlador_if;

    logic [9:0] VGA_X;
    logic [9:0] VGA_Y;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        output VGA_X, VGA_Y, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output VGA_R, VGA_G, VGA_B,
        input  pix_r, pix_g, pix_b
    );

    modport slave (
        input  VGA_X, VGA_Y, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input  VGA_R, VGA_G, VGA_B,
        output pix_r, pix_g, pix_b
    );

endinterface

// File: rtl/vga_linha_atraso.sv
// -----------------------------------------------------------------------------
// vga_linha_atraso
// Purpose : WIDTH x DEPTH shift register with a synchronous active-low reset
//           that loads every stage with RST_VAL.
// Ports   :
//   i_clk    clock
//   i_rst_n  synchronous reset, active low
//   i_d      data in
//   o_q      data out, DEPTH cycles after i_d
// -----------------------------------------------------------------------------
module vga_linha_atraso #(
    parameter int unsigned       WIDTH   = 3,
    parameter int unsigned       DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift chain; reset flushes every stage to the inactive value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_controlador.sv
// -----------------------------------------------------------------------------
// vga_controlador
// Purpose : VGA timing generator. Free-running H/V counters publish the raw
//           scan coordinate; HS/VS/BLANK_N are decoded from it, delayed to
//           match the renderer latency and registered together with the
//           returned colour. frame_start/line_start are direct counter decodes.
// Ports   :
//   VGA_CLK      pixel clock
//   reset        synchronous, active-low reset
//   test_mode    (only with VGA_TEST_PATTERN_EN) replace pix_* with colour bars
//   vga          vga_controlador_if.master (coordinates, pix_*, DAC pins)
//   frame_start  high while the scan sits at (0,0)
//   line_start   high while X==0
// Config  : VGA_TEST_PATTERN_EN adds test_mode and the 8-bar pattern generator.
// -----------------------------------------------------------------------------
module vga_controlador
    import vga_pkg::*;
#(
    parameter int unsigned PIPE_DELAY  = 1,
    parameter int unsigned P_H_SYNC    = H_SYNC,
    parameter int unsigned P_H_BACK    = H_BACK,
    parameter int unsigned P_H_VISIBLE = H_VISIBLE,
    parameter int unsigned P_H_FRONT   = H_FRONT,
    parameter int unsigned P_V_SYNC    = V_SYNC,
    parameter int unsigned P_V_BACK    = V_BACK,
    parameter int unsigned P_V_VISIBLE = V_VISIBLE,
    parameter int unsigned P_V_FRONT   = V_FRONT
) (
    input  logic              VGA_CLK,
    input  logic              reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    vga_controlador_if.master vga,
    output logic              frame_start,
    output logic              line_start
);

    // Renderer latency kept inside the supported 1..DEPTH_MAX range
    localparam int unsigned L_DEPTH = (PIPE_DELAY < 1) ? 1 :
                                      ((PIPE_DELAY > DEPTH_MAX) ? DEPTH_MAX : PIPE_DELAY);

    localparam logic [CNT_W-1:0] L_H_MAX = CNT_W'(P_H_SYNC + P_H_BACK + P_H_VISIBLE + P_H_FRONT - 1);
    localparam logic [CNT_W-1:0] L_V_MAX = CNT_W'(P_V_SYNC + P_V_BACK + P_V_VISIBLE + P_V_FRONT - 1);
    localparam logic [CNT_W-1:0] L_H_SE  = CNT_W'(P_H_SYNC);
    localparam logic [CNT_W-1:0] L_V_SE  = CNT_W'(P_V_SYNC);
    localparam logic [CNT_W-1:0] L_H_VS  = CNT_W'(P_H_SYNC + P_H_BACK);
    localparam logic [CNT_W-1:0] L_H_VE  = CNT_W'(P_H_SYNC + P_H_BACK + P_H_VISIBLE);
    localparam logic [CNT_W-1:0] L_V_VS  = CNT_W'(P_V_SYNC + P_V_BACK);
    localparam logic [CNT_W-1:0] L_V_VE  = CNT_W'(P_V_SYNC + P_V_BACK + P_V_VISIBLE);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_run;
    vga_tim_t         w_raw;
    vga_tim_t         w_dly;
    logic [7:0]       w_r;
    logic [7:0]       w_g;
    logic [7:0]       w_b;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;
    logic [7:0]       r_r;
    logic [7:0]       r_g;
    logic [7:0]       r_b;

    // Scan counters. r_run is clear while in reset, so the first edge after
    // release parks on (0,0) with the pulses live instead of skipping it.
    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            r_h   <= 10'd0;
            r_v   <= 10'd0;
            r_run <= 1'b0;
        end else if (!r_run) begin
            r_h   <= 10'd0;
            r_v   <= 10'd0;
            r_run <= 1'b1;
        end else if (r_h == L_H_MAX) begin
            r_h <= 10'd0;
            if (r_v == L_V_MAX) begin
                r_v <= 10'd0;
            end else begin
                r_v <= r_v + 10'd1;
            end
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    // Region decode of the current coordinate; idle values while held in reset
    always_comb begin
        w_raw = TIM_IDLE;
        if (r_run) begin
            w_raw.hs  = (r_h >= L_H_SE);
            w_raw.vs  = (r_v >= L_V_SE);
            w_raw.vis = (r_h >= L_H_VS) && (r_h < L_H_VE) && (r_v >= L_V_VS) && (r_v < L_V_VE);
        end else begin
            w_raw = TIM_IDLE;
        end
    end

    vga_linha_atraso #(
        .WIDTH   (3),
        .DEPTH   (L_DEPTH),
        .RST_VAL (TIM_IDLE)
    ) u_tim_dly (
        .i_clk   (VGA_CLK),
        .i_rst_n (reset),
        .i_d     (w_raw),
        .o_q     (w_dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] L_BAR_W = CNT_W'(P_H_VISIBLE / 8);

    logic [CNT_W-1:0] w_x_dly;
    logic [CNT_W-1:0] w_bar_q;

    // X travels alongside the timing bits so the bar index matches the slot
    vga_linha_atraso #(
        .WIDTH   (CNT_W),
        .DEPTH   (L_DEPTH),
        .RST_VAL (10'd0)
    ) u_x_dly (
        .i_clk   (VGA_CLK),
        .i_rst_n (reset),
        .i_d     (r_h),
        .o_q     (w_x_dly)
    );

    assign w_bar_q = (w_x_dly - L_H_VS) / L_BAR_W;

    // Bar pattern or renderer colour; out-of-range indices are blanked later
    always_comb begin
        w_r = vga.pix_r;
        w_g = vga.pix_g;
        w_b = vga.pix_b;
        if (test_mode) begin
            w_r = bar_level(w_bar_q[2]);
            w_g = bar_level(w_bar_q[1]);
            w_b = bar_level(w_bar_q[0]);
        end else begin
            w_r = vga.pix_r;
            w_g = vga.pix_g;
            w_b = vga.pix_b;
        end
    end
`else
    // Renderer colour passes straight to the output register
    always_comb begin
        w_r = vga.pix_r;
        w_g = vga.pix_g;
        w_b = vga.pix_b;
    end
`endif

    // Output register: delayed syncs and blank-gated colour leave together
    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_r       <= 8'h00;
            r_g       <= 8'h00;
            r_b       <= 8'h00;
        end else begin
            r_hs      <= w_dly.hs;
            r_vs      <= w_dly.vs;
            r_blank_n <= w_dly.vis;
            r_r       <= w_dly.vis ? w_r : 8'h00;
            r_g       <= w_dly.vis ? w_g : 8'h00;
            r_b       <= w_dly.vis ? w_b : 8'h00;
        end
    end

    assign vga.VGA_X       = r_h;
    assign vga.VGA_Y       = r_v;
    assign vga.VGA_HS      = r_hs;
    assign vga.VGA_VS      = r_vs;
    assign vga.VGA_BLANK_N = r_blank_n;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_R       = r_r;
    assign vga.VGA_G       = r_g;
    assign vga.VGA_B       = r_b;

    assign line_start  = r_run && (r_h == 10'd0);
    assign frame_start = r_run && (r_h == 10'd0) && (r_v == 10'd0);

endmodule
